// File: rtl/ir_fetch_queue_if.sv
// Fetch/decode handshake bundle for ir_fetch_queue: fetch-side push, decode-side pop,
// flush, and the head entry pre-split into MIPS fields.
interface ir_fetch_queue_if #(
   parameter int DEPTH = 4
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [31:0]      inst;
   logic             instValid;
   logic             instReady;
   logic             decReady;
   logic             decValid;
   logic             flush;
   logic [5:0]       opcode;
   logic [4:0]       rs;
   logic [4:0]       rt;
   logic [4:0]       rd;
   logic [4:0]       shamt;
   logic [5:0]       funct;
   logic [15:0]      imme;
   logic [31:0]      immExt;
   logic [25:0]      target;
   logic [PTR_W:0]   count;

   modport master (
      output inst, instValid, decReady, flush,
      input  instReady, decValid, opcode, rs, rt, rd, shamt, funct,
             imme, immExt, target, count
   );

   modport slave (
      input  inst, instValid, decReady, flush,
      output instReady, decValid, opcode, rs, rt, rd, shamt, funct,
             imme, immExt, target, count
   );
endinterface

// File: rtl/ir_fetch_queue.sv
// DEPTH-entry instruction FIFO; head word shows up decoded one edge after its push, with no
// comb path from inst. Ready/valid come from the count only; flush beats push and pop.
module ir_fetch_queue #(
   parameter int DEPTH    = 4,
   parameter bit IMM_SEXT = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   ir_fetch_queue_if.slave   q_if
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   logic [31:0]      mem_q [DEPTH];
   logic [PTR_W-1:0] wp_q, wp_d;
   logic [PTR_W-1:0] rp_q, rp_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             push, pop;
   logic [31:0]      head;

   assign q_if.instReady = (count_q != FULL_CNT);
   assign q_if.decValid  = (count_q != '0);

   assign push = q_if.instValid && q_if.instReady;
   assign pop  = q_if.decValid && q_if.decReady;

   always_comb begin
      wp_d    = wp_q;
      rp_d    = rp_q;
      count_d = count_q;
      if (q_if.flush) begin
         wp_d    = '0;
         rp_d    = '0;
         count_d = '0;
      end else begin
         if (push) wp_d = wp_q + 1'b1;
         if (pop)  rp_d = rp_q + 1'b1;
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp_q    <= '0;
         rp_q    <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         count_q <= count_d;
         // Array contents survive a flush; only the pointers are rewound.
         if (push && !q_if.flush) mem_q[wp_q] <= q_if.inst;
      end
   end

   // Gating keeps the decode fields at zero whenever no entry is valid.
   assign head = q_if.decValid ? mem_q[rp_q] : 32'd0;

   assign q_if.opcode = head[31:26];
   assign q_if.rs     = head[25:21];
   assign q_if.rt     = head[20:16];
   assign q_if.rd     = head[15:11];
   assign q_if.shamt  = head[10:6];
   assign q_if.funct  = head[5:0];
   assign q_if.imme   = head[15:0];
   assign q_if.target = head[25:0];
   assign q_if.immExt = IMM_SEXT ? {{16{head[15]}}, head[15:0]} : {16'd0, head[15:0]};
   assign q_if.count  = count_q;
endmodule

// File: tb/tb_ir_fetch_queue.sv
// Bench for ir_fetch_queue: decode vector table, hand sequences for full/wrap/flush/reset,
// and randomized traffic compared against a queue-based reference model.
module tb_ir_fetch_queue;
   localparam int DEPTH    = 4;
   localparam bit IMM_SEXT = 1'b1;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   chk_cnt  = 0;
   int   pass_cnt = 0;
   logic [31:0] mq [$];

   always #5 clk = ~clk;

   ir_fetch_queue_if #(.DEPTH(DEPTH)) bus ();
   ir_fetch_queue #(.DEPTH(DEPTH), .IMM_SEXT(IMM_SEXT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .q_if  (bus)
   );

   typedef struct {
      logic [31:0] word;
      logic [5:0]  opcode;
      logic [4:0]  rs, rt, rd, shamt;
      logic [5:0]  funct;
      logic [31:0] immExt;
      logic [25:0] target;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   function automatic logic [31:0] head_word();
      return {bus.opcode, bus.rs, bus.rt, bus.rd, bus.shamt, bus.funct};
   endfunction

   function automatic logic [31:0] ext(input logic [31:0] w);
      return IMM_SEXT ? {{16{w[15]}}, w[15:0]} : {16'd0, w[15:0]};
   endfunction

   // Compare every observable output with what the model queue implies.
   task automatic check_state(input string tag);
      logic [31:0] h;
      h = (mq.size() != 0) ? mq[0] : 32'd0;
      chk({tag, ".count"},     32'(bus.count),     32'(mq.size()));
      chk({tag, ".decValid"},  32'(bus.decValid),  32'(mq.size() != 0));
      chk({tag, ".instReady"}, 32'(bus.instReady), 32'(mq.size() != DEPTH));
      chk({tag, ".fields"},    head_word(),        h);
      chk({tag, ".immExt"},    bus.immExt,         ext(h));
      chk({tag, ".target"},    32'(bus.target),    {6'd0, h[25:0]});
   endtask

   task automatic cycle(input logic iv, input logic [31:0] w, input logic dr, input logic fl);
      bit do_push, do_pop;
      logic [31:0] tmp;
      bus.instValid = iv;
      bus.inst      = w;
      bus.decReady  = dr;
      bus.flush     = fl;
      do_push = iv && (mq.size() < DEPTH);
      do_pop  = dr && (mq.size() > 0);
      @(posedge clk);
      #1;
      if (fl) mq.delete();
      else begin
         if (do_pop) tmp = mq.pop_front();
         if (do_push) mq.push_back(w);
      end
   endtask

   task automatic idle();
      bus.instValid = 1'b0;
      bus.decReady  = 1'b0;
      bus.flush     = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      vec_t vecs [4];
      bus.inst      = 32'd0;
      bus.instValid = 1'b0;
      bus.decReady  = 1'b0;
      bus.flush     = 1'b0;

      vecs[0] = '{32'h8C22FFFC, 6'h23, 5'd1, 5'd2,  5'h1F, 5'h1F, 6'h3C, 32'hFFFFFFFC, 26'h022FFFC};
      vecs[1] = '{32'h012A4020, 6'h00, 5'd9, 5'd10, 5'd8,  5'd0,  6'h20, 32'h00004020, 26'h12A4020};
      vecs[2] = '{32'h08000010, 6'h02, 5'd0, 5'd0,  5'd0,  5'd0,  6'h10, 32'h00000010, 26'h0000010};
      vecs[3] = '{32'h20087FFF, 6'h08, 5'd0, 5'd8,  5'h0F, 5'h1F, 6'h3F, 32'h00007FFF, 26'h0087FFF};

      // Reset state
      #2 rst_n = 1'b0;
      @(posedge clk); #1;
      chk("rst.decValid",  32'(bus.decValid),  32'd0);
      chk("rst.instReady", 32'(bus.instReady), 32'd1);
      chk("rst.count",     32'(bus.count),     32'd0);
      chk("rst.fields",    head_word(),        32'd0);
      chk("rst.immExt",    bus.immExt,         32'd0);
      chk("rst.target",    32'(bus.target),    32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Decode table: push into empty queue, check fields next cycle, then pop.
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, vecs[i].word, 1'b0, 1'b0);
         idle();
         chk($sformatf("vec%0d.decValid", i), 32'(bus.decValid), 32'd1);
         chk($sformatf("vec%0d.opcode", i),   32'(bus.opcode),   32'(vecs[i].opcode));
         chk($sformatf("vec%0d.rs", i),       32'(bus.rs),       32'(vecs[i].rs));
         chk($sformatf("vec%0d.rt", i),       32'(bus.rt),       32'(vecs[i].rt));
         chk($sformatf("vec%0d.rd", i),       32'(bus.rd),       32'(vecs[i].rd));
         chk($sformatf("vec%0d.shamt", i),    32'(bus.shamt),    32'(vecs[i].shamt));
         chk($sformatf("vec%0d.funct", i),    32'(bus.funct),    32'(vecs[i].funct));
         chk($sformatf("vec%0d.imme", i),     32'(bus.imme),     {16'd0, vecs[i].word[15:0]});
         chk($sformatf("vec%0d.immExt", i),   bus.immExt,        vecs[i].immExt);
         chk($sformatf("vec%0d.target", i),   32'(bus.target),   {6'd0, vecs[i].target});
         cycle(1'b0, 32'd0, 1'b1, 1'b0);
         idle();
         check_state($sformatf("vec%0d.popped", i));
      end

      // Fill to full, then wrap-around order.
      for (int i = 1; i <= 4; i++) cycle(1'b1, 32'(i), 1'b0, 1'b0);
      idle();
      chk("full.count",     32'(bus.count),     32'd4);
      chk("full.instReady", 32'(bus.instReady), 32'd0);
      cycle(1'b1, 32'hDEAD0000, 1'b1, 1'b0);   // full: push must be dropped
      idle();
      chk("fullpop.count", 32'(bus.count), 32'd3);
      cycle(1'b1, 32'd5, 1'b0, 1'b0);
      idle();
      for (int i = 2; i <= 5; i++) begin
         chk($sformatf("wrap.head%0d", i), head_word(), 32'(i));
         cycle(1'b0, 32'd0, 1'b1, 1'b0);
      end
      idle();
      check_state("wrap.empty");

      // Simultaneous push/pop at count=2.
      cycle(1'b1, 32'h11110000, 1'b0, 1'b0);
      cycle(1'b1, 32'h22220000, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         logic [31:0] exp_head;
         exp_head = mq[0];
         cycle(1'b1, 32'h33330000 + 32'(i), 1'b1, 1'b0);
         chk($sformatf("pp%0d.count", i), 32'(bus.count), 32'd2);
         check_state($sformatf("pp%0d", i));
         chk($sformatf("pp%0d.advanced", i), 32'(head_word() != exp_head), 32'd1);
      end
      idle();

      // Flush at count=3 with a coincident push.
      cycle(1'b1, 32'h44440000, 1'b0, 1'b0);
      chk("preflush.count", 32'(bus.count), 32'd3);
      cycle(1'b1, 32'hFEEDBEEF, 1'b1, 1'b1);
      idle();
      chk("flush.count",    32'(bus.count),    32'd0);
      chk("flush.decValid", 32'(bus.decValid), 32'd0);
      chk("flush.fields",   head_word(),       32'd0);
      cycle(1'b0, 32'd0, 1'b0, 1'b0);
      chk("flush.noword", 32'(bus.decValid), 32'd0);

      // Asynchronous reset mid-operation.
      cycle(1'b1, 32'h55550000, 1'b0, 1'b0);
      cycle(1'b1, 32'h66660000, 1'b0, 1'b0);
      idle();
      #1 rst_n = 1'b0;
      #1;
      chk("arst.count",    32'(bus.count),    32'd0);
      chk("arst.decValid", 32'(bus.decValid), 32'd0);
      mq.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      check_state("arst.after");

      // Randomized traffic against the model.
      for (int i = 0; i < 300; i++) begin
         cycle(1'($urandom_range(0, 99) < 60), $urandom(), 1'($urandom_range(0, 99) < 50),
               1'($urandom_range(0, 99) < 4));
         check_state($sformatf("rnd%0d", i));
      end
      idle();

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
